pong_game_ctrl: RTL

Game sequencer for the two-player pong display path. It drives `gra_still` into the pong graphics block, consumes that block's `hit_A`, `hit_B` and `miss` strobes, and keeps the score. It also runs the newgame / serve / play / game-over state machine and flags the winner. It sits between the debounced start button and the graphics block, alongside the text/score overlay that reads its outputs.

---
 rtl/pong_game_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: IDLE/SERVE/PLAY/OVER control, scoring and winner flag.
// Optional rally statistics are built when PONG_RALLY_STATS_EN is defined.
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       hit_A,
    input  logic       hit_B,
    input  logic       miss,
    output logic       gra_still,
    output logic [3:0] score_A,
    output logic [3:0] score_B,
    output logic [1:0] winner,
    output logic [1:0] state,
    output logic [7:0] rally_cnt,
    output logic [7:0] rally_max
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SERVE = 2'b01,
        S_PLAY  = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] score_a_q, score_a_d;
    logic [3:0] score_b_q, score_b_d;
    logic [1:0] winner_q, winner_d;
    logic       last_b_q, last_b_d;   // 0: A hit last, 1: B hit last
    logic       start_q, hit_a_q, hit_b_q, miss_q;
    logic       start_ev, hit_a_ev, hit_b_ev, miss_ev;
    logic [3:0] point;

    assign start_ev = start & ~start_q;
    assign hit_a_ev = hit_A & ~hit_a_q;
    assign hit_b_ev = hit_B & ~hit_b_q;
    assign miss_ev  = miss  & ~miss_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            hit_a_q <= 1'b0;
            hit_b_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            start_q <= start;
            hit_a_q <= hit_A;
            hit_b_q <= hit_B;
            miss_q  <= miss;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= 8'd0;
            score_a_q <= 4'd0;
            score_b_q <= 4'd0;
            winner_q  <= 2'b00;
            last_b_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            winner_q  <= winner_d;
            last_b_q  <= last_b_d;
        end
    end

    assign point = (last_b_q ? score_b_q : score_a_q) + 4'd1;

    always_comb begin
        // NOTE: hold-current defaults first keep every path assigned, so no latches are inferred.
        state_d   = state_q;
        timer_d   = timer_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        winner_d  = winner_q;
        last_b_d  = last_b_q;
        case (state_q)
            S_IDLE: begin
                if (start_ev) begin
                    state_d = S_SERVE;
                    timer_d = SERVE_LOAD;
                end
            end
            S_SERVE: begin
                if (tick) begin
                    timer_d = timer_q - 8'd1;
                    if (timer_q == 8'd1) begin
                        state_d  = S_PLAY;
                        last_b_d = 1'b0;
                    end
                end
            end
            S_PLAY: begin
                // A miss outranks any hit in the same cycle; the hit is dropped.
                if (miss_ev) begin
                    if (last_b_q) score_b_d = point;
                    else          score_a_d = point;
                    if (point == WIN) begin
                        state_d  = S_OVER;
                        winner_d = last_b_q ? 2'b10 : 2'b01;
                    end else begin
                        state_d = S_SERVE;
                        timer_d = SERVE_LOAD;
                    end
                end else if (hit_a_ev) begin
                    last_b_d = 1'b0;
                end else if (hit_b_ev) begin
                    last_b_d = 1'b1;
                end
            end
            S_OVER: begin
                if (start_ev) begin
                    state_d   = S_IDLE;
                    score_a_d = 4'd0;
                    score_b_d = 4'd0;
                    winner_d  = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gra_still = (state_q != S_PLAY);
    assign score_A   = score_a_q;
    assign score_B   = score_b_q;
    assign winner    = winner_q;
    assign state     = state_q;

`ifdef PONG_RALLY_STATS_EN
    logic [7:0] rally_cnt_q, rally_max_q;
    logic       rally_clr, rally_inc, rally_cap, rally_max_clr;

    assign rally_clr     = (state_q == S_SERVE) && tick && (timer_q == 8'd1);
    assign rally_inc     = (state_q == S_PLAY) && !miss_ev && (hit_a_ev || hit_b_ev);
    assign rally_cap     = (state_q == S_PLAY) && miss_ev;
    assign rally_max_clr = (state_q == S_IDLE) && start_ev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rally_cnt_q <= 8'd0;
            rally_max_q <= 8'd0;
        end else begin
            if (rally_clr)
                rally_cnt_q <= 8'd0;
            else if (rally_inc && rally_cnt_q != 8'hFF)
                rally_cnt_q <= rally_cnt_q + 8'd1;
            if (rally_max_clr)
                rally_max_q <= 8'd0;
            else if (rally_cap && rally_cnt_q > rally_max_q)
                rally_max_q <= rally_cnt_q;
        end
    end

    assign rally_cnt = rally_cnt_q;
    assign rally_max = rally_max_q;
`else
    assign rally_cnt = 8'd0;
    assign rally_max = 8'd0;
`endif

endmodule
